// File: rtl/mc_controller.sv
// Multicycle ARMv4-subset control unit: Moore sequencer, DP/mem/branch decode, NZCV flags and condition gating.
// Outputs decode from the state register (plus Instr for RegSrc/ImmSrc/ALUControl); write enables are held low during reset.
module mc_controller (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:12] Instr,
  input  logic [3:0]   ALUFlags,
  output logic         PCWrite,
  output logic         AdrSrc,
  output logic         MemWrite,
  output logic         IRWrite,
  output logic         RegWrite,
  output logic [1:0]   RegSrc,
  output logic [1:0]   ImmSrc,
  output logic         ALUSrcA,
  output logic [1:0]   ALUSrcB,
  output logic [1:0]   ResultSrc,
  output logic [2:0]   ALUControl,
  output logic [3:0]   State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t     state;
  logic [3:0] flags;
  logic       cond_reg;

  logic [3:0] cond;
  logic [1:0] op;
  logic [3:0] cmd;
  logic       s_bit;
  logic       rd_pc;
  logic       unused_rn;

  assign cond      = Instr[31:28];
  assign op        = Instr[27:26];
  assign cmd       = Instr[24:21];
  assign s_bit     = Instr[20];
  assign rd_pc     = (Instr[15:12] == 4'hF);
  assign unused_rn = ^Instr[19:16];

  // Condition evaluation against the architectural flags {N,Z,C,V}
  logic cond_ex;
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = flags[2];
      4'b0001: cond_ex = ~flags[2];
      4'b0010: cond_ex = flags[1];
      4'b0011: cond_ex = ~flags[1];
      4'b0100: cond_ex = flags[3];
      4'b0101: cond_ex = ~flags[3];
      4'b0110: cond_ex = flags[0];
      4'b0111: cond_ex = ~flags[0];
      4'b1000: cond_ex = flags[1] & ~flags[2];
      4'b1001: cond_ex = ~flags[1] | flags[2];
      4'b1010: cond_ex = (flags[3] == flags[0]);
      4'b1011: cond_ex = (flags[3] != flags[0]);
      4'b1100: cond_ex = ~flags[2] & (flags[3] == flags[0]);
      4'b1101: cond_ex = flags[2] | (flags[3] != flags[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  logic [2:0] dp_alu;
  logic       dp_ok;
  logic       no_wb;
  always_comb begin
    dp_alu = 3'b000;
    dp_ok  = 1'b1;
    case (cmd)
      4'b0000: dp_alu = 3'b010;
      4'b1100: dp_alu = 3'b011;
      4'b0010: dp_alu = 3'b001;
      4'b0100: dp_alu = 3'b000;
      4'b1000: dp_alu = 3'b010;
      4'b1010: dp_alu = 3'b001;
      4'b0001: dp_alu = 3'b100;
      4'b1101: dp_alu = 3'b110;
      default: dp_ok  = 1'b0;
    endcase
    no_wb = ~dp_ok | (cmd == 4'b1000) | (cmd == 4'b1010);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      flags    <= 4'b0000;
      cond_reg <= 1'b0;
    end else begin
      case (state)
        FETCH:   state <= DECODE;
        DECODE: begin
          cond_reg <= cond_ex;
          case (op)
            2'b01:   state <= MEMADR;
            2'b00:   state <= Instr[25] ? EXECI : EXECR;
            2'b10:   state <= BRANCH;
            default: state <= FETCH;
          endcase
        end
        MEMADR:  state <= s_bit ? MEMREAD : MEMWRITE;
        MEMREAD: state <= MEMWB;
        EXECR, EXECI: begin
          // C and V only carry meaning for the adder ops
          if (s_bit && cond_ex && dp_ok) begin
            flags[3:2] <= ALUFlags[3:2];
            if (dp_alu == 3'b000 || dp_alu == 3'b001)
              flags[1:0] <= ALUFlags[1:0];
          end
          state <= ALUWB;
        end
        default: state <= FETCH;
      endcase
    end
  end

  logic pc_en, ir_en, mem_en, reg_en;
  always_comb begin
    pc_en      = 1'b0;
    ir_en      = 1'b0;
    mem_en     = 1'b0;
    reg_en     = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 3'b000;
    case (state)
      FETCH: begin
        ir_en = 1'b1; pc_en = 1'b1;
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      MEMADR:   ALUSrcB = 2'b01;
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        if (rd_pc) pc_en = cond_reg;
        else       reg_en = cond_reg;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1; mem_en = cond_reg;
      end
      EXECR:    ALUControl = dp_alu;
      EXECI: begin
        ALUSrcB = 2'b01; ALUControl = dp_alu;
      end
      ALUWB: begin
        if (!no_wb) begin
          if (rd_pc) pc_en = cond_reg;
          else       reg_en = cond_reg;
        end
      end
      BRANCH: begin
        ALUSrcB = 2'b01; ResultSrc = 2'b10; pc_en = cond_reg;
      end
      default: ;
    endcase
  end

  assign PCWrite  = pc_en & ~reset;
  assign IRWrite  = ir_en & ~reset;
  assign MemWrite = mem_en & ~reset;
  assign RegWrite = reg_en & ~reset;
  assign RegSrc   = {(op == 2'b01) & ~s_bit, (op == 2'b10)};
  assign ImmSrc   = op;
  assign State    = state;

endmodule

// File: tb/tb_mc_controller.sv
// Directed per-cycle vectors for mc_controller, plus a hand-written reset-abort sequence.
module tb_mc_controller;
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [31:12] instr_in = '0;
  logic [3:0]   alu_flags = 4'b0000;
  logic         PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
  logic [1:0]   RegSrc, ImmSrc, ALUSrcB, ResultSrc;
  logic [2:0]   ALUControl;
  logic [3:0]   State;

  mc_controller dut (
    .clk(clk), .reset(reset), .Instr(instr_in), .ALUFlags(alu_flags),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .RegSrc(RegSrc), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUControl(ALUControl), .State(State)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] ADDS  = 32'hE2901005;
  localparam logic [31:0] LDR   = 32'hE5902004;
  localparam logic [31:0] STR   = 32'hE5802004;
  localparam logic [31:0] CMP   = 32'hE1500000;
  localparam logic [31:0] BEQ   = 32'h0A000002;
  localparam logic [31:0] ADDNE = 32'h12901005;
  localparam logic [31:0] RSBS  = 32'hE0701002;
  localparam logic [31:0] MOVPC = 32'hE1A0F002;
  localparam logic [31:0] NOP   = 32'hEC000000;
  localparam logic [31:0] ANDS  = 32'hE2101001;
  localparam logic [31:0] BCS   = 32'h2A000002;

  // exp = {State, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, RegSrc, ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl}
  typedef struct {
    logic        rst;
    logic [31:0] instr;
    logic [3:0]  fl;
    logic [20:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input logic rst, input logic [31:0] instr, input logic [3:0] fl,
                     input logic [3:0] st, input logic [4:0] strb, input logic [1:0] rs,
                     input logic [1:0] imm, input logic asa, input logic [1:0] asb,
                     input logic [1:0] res, input logic [2:0] alu);
    vec_t v;
    v.rst = rst; v.instr = instr; v.fl = fl;
    v.exp = {st, strb, rs, imm, asa, asb, res, alu};
    vecs.push_back(v);
  endtask

  function automatic logic [20:0] actual();
    return {State, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, RegSrc, ImmSrc,
            ALUSrcA, ALUSrcB, ResultSrc, ALUControl};
  endfunction

  task automatic check(input string name, input logic [20:0] exp);
    logic [20:0] got;
    got = actual();
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got st=%0d ctl=%b, want st=%0d ctl=%b",
               name, got[20:17], got[16:0], exp[20:17], exp[16:0]);
    end
  endtask

  // Standard DP instruction: FETCH, DECODE, EXEC, ALUWB
  task automatic dp(input logic [31:0] instr, input logic [3:0] fl, input logic [3:0] ex_st,
                    input logic [1:0] ex_asb, input logic [2:0] alu, input logic [4:0] wb_strb);
    add(0, instr, fl, 4'd0, 5'b10010, 2'b00, 2'b00, 1, 2'b10, 2'b10, 3'b000);
    add(0, instr, fl, 4'd1, 5'b00000, 2'b00, 2'b00, 1, 2'b10, 2'b10, 3'b000);
    add(0, instr, fl, ex_st, 5'b00000, 2'b00, 2'b00, 0, ex_asb, 2'b00, alu);
    add(0, instr, fl, 4'd8, wb_strb, 2'b00, 2'b00, 0, 2'b00, 2'b00, 3'b000);
  endtask

  // Branch: FETCH, DECODE, BRANCH with the expected PCWrite in BRANCH
  task automatic br(input logic [31:0] instr, input logic taken);
    add(0, instr, 4'b0000, 4'd0, 5'b10010, 2'b01, 2'b10, 1, 2'b10, 2'b10, 3'b000);
    add(0, instr, 4'b0000, 4'd1, 5'b00000, 2'b01, 2'b10, 1, 2'b10, 2'b10, 3'b000);
    add(0, instr, 4'b0000, 4'd9, {taken, 4'b0000}, 2'b01, 2'b10, 0, 2'b01, 2'b10, 3'b000);
  endtask

  initial begin
    // reset held
    add(1, 32'h0, 4'b0000, 4'd0, 5'b00000, 2'b00, 2'b00, 1, 2'b10, 2'b10, 3'b000);
    add(1, 32'h0, 4'b0000, 4'd0, 5'b00000, 2'b00, 2'b00, 1, 2'b10, 2'b10, 3'b000);
    dp(ADDS, 4'b0000, 4'd7, 2'b01, 3'b000, 5'b00001);
    // LDR
    add(0, LDR, 4'b0000, 4'd0, 5'b10010, 2'b00, 2'b01, 1, 2'b10, 2'b10, 3'b000);
    add(0, LDR, 4'b0000, 4'd1, 5'b00000, 2'b00, 2'b01, 1, 2'b10, 2'b10, 3'b000);
    add(0, LDR, 4'b0000, 4'd2, 5'b00000, 2'b00, 2'b01, 0, 2'b01, 2'b00, 3'b000);
    add(0, LDR, 4'b0000, 4'd3, 5'b01000, 2'b00, 2'b01, 0, 2'b00, 2'b00, 3'b000);
    add(0, LDR, 4'b0000, 4'd4, 5'b00001, 2'b00, 2'b01, 0, 2'b00, 2'b01, 3'b000);
    // STR
    add(0, STR, 4'b0000, 4'd0, 5'b10010, 2'b10, 2'b01, 1, 2'b10, 2'b10, 3'b000);
    add(0, STR, 4'b0000, 4'd1, 5'b00000, 2'b10, 2'b01, 1, 2'b10, 2'b10, 3'b000);
    add(0, STR, 4'b0000, 4'd2, 5'b00000, 2'b10, 2'b01, 0, 2'b01, 2'b00, 3'b000);
    add(0, STR, 4'b0000, 4'd5, 5'b01100, 2'b10, 2'b01, 0, 2'b00, 2'b00, 3'b000);
    dp(CMP, 4'b0100, 4'd6, 2'b00, 3'b001, 5'b00000);    // sets Z=1, no writeback
    br(BEQ, 1'b1);
    dp(ADDNE, 4'b0000, 4'd7, 2'b01, 3'b000, 5'b00000);  // skipped, Z must stay 1
    br(BEQ, 1'b1);
    dp(ADDS, 4'b0000, 4'd7, 2'b01, 3'b000, 5'b00001);   // flags back to 0000
    dp(RSBS, 4'b0100, 4'd6, 2'b00, 3'b000, 5'b00000);   // unsupported cmd: no flag or reg write
    br(BEQ, 1'b0);
    dp(MOVPC, 4'b0000, 4'd6, 2'b00, 3'b110, 5'b10000);
    // NOP: DECODE returns straight to FETCH
    add(0, NOP, 4'b0000, 4'd0, 5'b10010, 2'b00, 2'b11, 1, 2'b10, 2'b10, 3'b000);
    add(0, NOP, 4'b0000, 4'd1, 5'b00000, 2'b00, 2'b11, 1, 2'b10, 2'b10, 3'b000);
    dp(ANDS, 4'b0010, 4'd7, 2'b01, 3'b010, 5'b00001);   // C must not load on logical op
    br(BCS, 1'b0);
    dp(ADDS, 4'b0010, 4'd7, 2'b01, 3'b000, 5'b00001);   // C loads on ADD
    br(BCS, 1'b1);
    add(0, STR, 4'b0000, 4'd0, 5'b10010, 2'b10, 2'b01, 1, 2'b10, 2'b10, 3'b000);
    add(0, STR, 4'b0000, 4'd1, 5'b00000, 2'b10, 2'b01, 1, 2'b10, 2'b10, 3'b000);
    add(0, STR, 4'b0000, 4'd2, 5'b00000, 2'b10, 2'b01, 0, 2'b01, 2'b00, 3'b000);

    #1 reset = 1'b1;
    foreach (vecs[i]) begin
      @(negedge clk);
      reset     = vecs[i].rst;
      instr_in  = vecs[i].instr[31:12];
      alu_flags = vecs[i].fl;
      #1;
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Reset asserted while in MEMWRITE aborts the store immediately
    @(negedge clk);
    #1 check("memwrite_before_reset", {4'd5, 5'b01100, 2'b10, 2'b01, 1'b0, 2'b00, 2'b00, 3'b000});
    #2 reset = 1'b1;
    #1 check("reset_in_memwrite", {4'd0, 5'b00000, 2'b10, 2'b01, 1'b1, 2'b10, 2'b10, 3'b000});
    @(negedge clk);
    #1 check("reset_hold", {4'd0, 5'b00000, 2'b10, 2'b01, 1'b1, 2'b10, 2'b10, 3'b000});
    reset = 1'b0;
    #1 check("fetch_after_release", {4'd0, 5'b10010, 2'b10, 2'b01, 1'b1, 2'b10, 2'b10, 3'b000});
    @(negedge clk);
    #1 check("decode_after_release", {4'd1, 5'b00000, 2'b10, 2'b01, 1'b1, 2'b10, 2'b10, 3'b000});

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mc_controller.md
# mc_controller

Control unit for the multicycle ARMv4-subset core. The core shares one memory for instructions and data and reuses one ALU for PC increment, address generation and execution. mc_controller sequences that datapath through a Moore state machine, decodes the instruction held in the datapath's instruction register, and owns the NZCV flag register and conditional-execution gating. It supports DP (AND, ORR, SUB, ADD, TST, CMP, EOR, MOV), LDR/STR with imm12, and B.

## Interface
Parameters: none.
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears state, flags and latched condition
- Instr  in  20  [31:12] of the instruction register output; stable from the end of FETCH until the next FETCH
- ALUFlags  in  4  {N,Z,C,V} from the ALU, valid in the same cycle as the result
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write enable
- IRWrite  out  1  instruction register enable
- RegWrite  out  1  register file write enable
- RegSrc  out  2  [0] = 1 reads R15 on port 1 (B); [1] = 1 reads Rd on port 2 (STR)
- ImmSrc  out  2  extend select, equal to Op = Instr[27:26]
- ALUSrcA  out  1  0 = RD1 register, 1 = PC
- ALUSrcB  out  2  00 = WriteData register, 01 = ExtImm, 10 = constant 4
- ResultSrc  out  2  00 = ALUOut, 01 = Data register, 10 = ALUResult
- ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 110 MOV
- State  out  4  current state encoding, for debug and verification

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9. Codes 10–15 return to FETCH.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1. Next state DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10 (forms PC+8 for R15 reads). Latch CondEx into CondReg. Next state by Op:
  - Op 01 -> MEMADR
  - Op 00 with Funct[5]=0 -> EXECR
  - Op 00 with Funct[5]=1 -> EXECI
  - Op 10 -> BRANCH
  - Op 11 -> FETCH (NOP)
- MEMADR: ALUSrcA=0, ALUSrcB=01, ADD. Next state MEMREAD if L=Instr[20]=1, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Next state MEMWB.
- MEMWB: ResultSrc=01, RegWrite=CondReg. Next state FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=CondReg. Next state FETCH.
- EXECR: ALUSrcA=0, ALUSrcB=00, ALUControl from the DP decode. Next state ALUWB.
- EXECI: same as EXECR but ALUSrcB=01. Next state ALUWB.
- ALUWB: ResultSrc=00, RegWrite=CondReg, suppressed for TST and CMP. Next state FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondReg. Next state FETCH.
- DP decode from cmd = Instr[24:21]:
  - 0000 AND -> 010
  - 1100 ORR -> 011
  - 0010 SUB -> 001
  - 0100 ADD -> 000
  - 1000 TST -> 010
  - 1010 CMP -> 001
  - 0001 EOR -> 100
  - 1101 MOV -> 110
  - others -> 000 with RegWrite and flag writes suppressed
- Outside EXECR/EXECI, ALUControl follows the state's listed operation, or 000 where none is listed.
- Rd = R15: in MEMWB or ALUWB with Instr[15:12]=1111, PCWrite=CondReg and RegWrite=0.
- Flags: NZCV register, reset to 0. Updated only in EXECR/EXECI when S=Instr[20]=1 and the live CondEx=1.
  - N and Z load for every cmd.
  - C and V load only when ALUControl is 000 or 001.
- Condition codes 0000–1110 follow standard ARM semantics. 1111 evaluates as 0 (never).
- RegSrc[0] = (Op==10). RegSrc[1] = (Op==01 & L==0). Both are combinational from Instr.

## Timing
- Moore outputs decode from the state register. RegSrc, ImmSrc and ALUControl also depend on Instr, which is stable after the FETCH edge.
- Cycles per instruction: LDR 5, STR 4, DP 4, B 3, NOP 2. A failed condition costs the same cycles.
- CondReg is captured at the DECODE->next edge. A flag write in EXEC is visible to the next instruction's DECODE.
- Reset: state goes to FETCH, flags to 0, CondReg to 0.
  - While reset is high, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0.
  - Reset asserted mid-instruction aborts it with no further writes.
  - FETCH is executed on the first rising edge after reset deasserts.

## Test plan
- Reset, then release: State=0 and all write enables 0 during reset; first edge after release asserts IRWrite=PCWrite=1 and State then reads 1.
- ADDS R1,R0,#5 (0xE2901005) with ALUFlags=0000: sequence 0,1,7,8. ALUControl=000 in EXECI. RegWrite=1 only in ALUWB. Flags become 0000.
- LDR (0xE5902004): sequence 0,1,2,3,4 with AdrSrc=1 in MEMREAD. STR (0xE5802004): sequence 0,1,2,5 with MemWrite=1 only in state 5 and RegSrc=10.
- CMP R0,R0 (0xE1500000) with ALUFlags=0100: flags Z=1 and RegWrite stays 0. Then BEQ (0x0A000002): sequence 0,1,9 with PCWrite=1 in BRANCH. The same after flags Z=0: PCWrite=0 in BRANCH.
- Conditional skip: ADDNE with Z=1 gives RegWrite=0 in ALUWB and flags unchanged. MOV PC,R2 (0xE1A0F002) gives PCWrite=1 and RegWrite=0 in ALUWB.
- Op=11 instruction gives sequence 0,1,0 with no writes. Reset asserted in MEMWRITE gives MemWrite=0 immediately and State=0.
